// File: rtl/str_ofs_pkg.sv
// rtl/str_ofs_pkg.sv - shared types, defaults and log2 helper for the str_ofs_conv scheduler
package str_ofs_pkg;

  // Bits needed to represent x; for a power-of-2 lane count, log2(NB-1) is the lane index width.
  function automatic int log2(input int x);
    int r;
    int v;
    r = 0;
    v = x;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_BYTE_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_ID_WIDTH   = 4;
  localparam int DEF_CMD_DEPTH  = 4;
  localparam int NB             = DEF_DATA_WIDTH / DEF_BYTE_WIDTH;
  localparam int OFS_W          = log2(NB - 1);

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] saddr;
    logic [DEF_ADDR_WIDTH-1:0] daddr;
    logic [31:0]               blen;
    logic [DEF_ID_WIDTH-1:0]   id;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, CFG, RUN, DONE} sched_st_e;

endpackage

// File: rtl/sched_sync_fifo.sv
// rtl/sched_sync_fifo.sv - synchronous FIFO with registered full/empty flags
module sched_sync_fifo
  import str_ofs_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_full,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty
);

  localparam int AW = log2(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      w_wr_ptr_nxt;
  logic [AW:0]      w_rd_ptr_nxt;
  logic             r_full;
  logic             r_empty;
  logic             w_wr;
  logic             w_rd;

  assign w_wr         = i_wr_en & ~r_full;
  assign w_rd         = i_rd_en & ~r_empty;
  assign w_wr_ptr_nxt = r_wr_ptr + (AW + 1)'(w_wr);
  assign w_rd_ptr_nxt = r_rd_ptr + (AW + 1)'(w_rd);

  // Full is forced high through reset so the writer sees "not ready" until the cycle after release.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_full   <= 1'b1;
      r_empty  <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_full   <= (w_wr_ptr_nxt == {~w_rd_ptr_nxt[AW], w_rd_ptr_nxt[AW-1:0]});
      r_empty  <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
  assign o_full    = r_full;
  assign o_empty   = r_empty;

endmodule

// File: rtl/str_ofs_conv_sched.sv
// rtl/str_ofs_conv_sched.sv - command queue and one-at-a-time scheduler for str_ofs_conv
module str_ofs_conv_sched
  import str_ofs_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BYTE_WIDTH = DEF_BYTE_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ID_WIDTH   = DEF_ID_WIDTH,
  parameter int CMD_DEPTH  = DEF_CMD_DEPTH,
  localparam int LANES     = DATA_WIDTH / BYTE_WIDTH,
  localparam int OFS_BITS  = log2(LANES - 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cmd_vld,
  output logic                  o_cmd_rdy,
  input  logic [ADDR_WIDTH-1:0] i_cmd_saddr,
  input  logic [ADDR_WIDTH-1:0] i_cmd_daddr,
  input  logic [31:0]           i_cmd_blen,
  input  logic [ID_WIDTH-1:0]   i_cmd_id,
  output logic                  o_conv_vld,
  input  logic                  i_conv_rdy,
  output logic [OFS_BITS-1:0]   o_conv_s_ofs,
  output logic [OFS_BITS-1:0]   o_conv_m_ofs,
  output logic                  o_src_go,
  input  logic                  i_mon_tvld,
  input  logic                  i_mon_trdy,
  input  logic                  i_mon_tlast,
  output logic                  o_done_vld,
  input  logic                  i_done_rdy,
  output logic [ID_WIDTH-1:0]   o_done_id,
  output logic                  o_done_err,
  output logic                  o_busy
);

  // Only the address LSBs matter downstream, so the queue stores offsets rather than full addresses.
  localparam int FW = 2 * OFS_BITS + 32 + ID_WIDTH;

  sched_st_e           r_state;
  sched_st_e           w_state_nxt;
  logic [ID_WIDTH-1:0] r_id;
  logic [OFS_BITS-1:0] r_s_ofs;
  logic [OFS_BITS-1:0] r_m_ofs;
  logic [32:0]         r_exp_beats;
  logic [32:0]         r_beat_cnt;
  logic                r_err;
  logic                r_src_go;

  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_beat;
  logic [FW-1:0]       w_wr_data;
  logic [FW-1:0]       w_rd_data;
  logic [OFS_BITS-1:0] w_s_ofs;
  logic [OFS_BITS-1:0] w_m_ofs;
  logic [31:0]         w_blen;
  logic [ID_WIDTH-1:0] w_id;
  logic [32:0]         w_exp_beats;
  logic                w_unused_addr;

  assign w_wr_data     = {i_cmd_saddr[OFS_BITS-1:0], i_cmd_daddr[OFS_BITS-1:0], i_cmd_blen, i_cmd_id};
  assign w_unused_addr = ^{i_cmd_saddr[ADDR_WIDTH-1:OFS_BITS], i_cmd_daddr[ADDR_WIDTH-1:OFS_BITS]};

  sched_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (i_cmd_vld),
    .i_wr_data (w_wr_data),
    .o_full    (w_full),
    .i_rd_en   (w_pop),
    .o_rd_data (w_rd_data),
    .o_empty   (w_empty)
  );

  assign {w_s_ofs, w_m_ofs, w_blen, w_id} = w_rd_data;
  assign w_exp_beats = ({1'b0, w_blen} + 33'(w_m_ofs) + 33'(LANES - 1)) >> OFS_BITS;
  assign w_beat      = i_mon_tvld & i_mon_trdy;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = (w_blen == 32'd0) ? DONE : CFG;
        end
      end
      CFG:  if (i_conv_rdy) w_state_nxt = RUN;
      RUN:  if (w_beat && i_mon_tlast) w_state_nxt = DONE;
      DONE: if (i_done_rdy) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_id        <= '0;
      r_s_ofs     <= '0;
      r_m_ofs     <= '0;
      r_exp_beats <= '0;
      r_beat_cnt  <= '0;
      r_err       <= 1'b0;
      r_src_go    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_src_go <= (r_state == CFG) && i_conv_rdy;
      if (w_pop) begin
        r_id        <= w_id;
        r_s_ofs     <= w_s_ofs;
        r_m_ofs     <= w_m_ofs;
        r_exp_beats <= w_exp_beats;
        r_beat_cnt  <= '0;
        r_err       <= (w_blen == 32'd0);
      end
      // Overlong streams keep counting so the mismatch is still caught when tlast finally arrives.
      if (r_state == RUN && w_beat) begin
        r_beat_cnt <= r_beat_cnt + 33'd1;
        if (i_mon_tlast) begin
          r_err <= (r_beat_cnt + 33'd1) != r_exp_beats;
        end
      end
    end
  end

  assign o_cmd_rdy    = ~w_full;
  assign o_conv_vld   = (r_state == CFG);
  assign o_conv_s_ofs = r_s_ofs;
  assign o_conv_m_ofs = r_m_ofs;
  assign o_src_go     = r_src_go;
  assign o_done_vld   = (r_state == DONE);
  assign o_done_id    = r_id;
  assign o_done_err   = r_err;
  assign o_busy       = ~w_empty | (r_state != IDLE);

endmodule

// File: tb/tb_str_ofs_conv_sched.sv
// tb/tb_str_ofs_conv_sched.sv - scoreboard bench for str_ofs_conv_sched with a behavioural converter model
module tb_str_ofs_conv_sched;
  import str_ofs_pkg::*;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_cmd_vld;
  logic        o_cmd_rdy;
  logic [31:0] i_cmd_saddr;
  logic [31:0] i_cmd_daddr;
  logic [31:0] i_cmd_blen;
  logic [3:0]  i_cmd_id;
  logic        o_conv_vld;
  logic        i_conv_rdy;
  logic [1:0]  o_conv_s_ofs;
  logic [1:0]  o_conv_m_ofs;
  logic        o_src_go;
  logic        i_mon_tvld;
  logic        i_mon_trdy;
  logic        i_mon_tlast;
  logic        o_done_vld;
  logic        i_done_rdy;
  logic [3:0]  o_done_id;
  logic        o_done_err;
  logic        o_busy;

  always #5 clk = ~clk;

  str_ofs_conv_sched dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_cmd_vld    (i_cmd_vld),
    .o_cmd_rdy    (o_cmd_rdy),
    .i_cmd_saddr  (i_cmd_saddr),
    .i_cmd_daddr  (i_cmd_daddr),
    .i_cmd_blen   (i_cmd_blen),
    .i_cmd_id     (i_cmd_id),
    .o_conv_vld   (o_conv_vld),
    .i_conv_rdy   (i_conv_rdy),
    .o_conv_s_ofs (o_conv_s_ofs),
    .o_conv_m_ofs (o_conv_m_ofs),
    .o_src_go     (o_src_go),
    .i_mon_tvld   (i_mon_tvld),
    .i_mon_trdy   (i_mon_trdy),
    .i_mon_tlast  (i_mon_tlast),
    .o_done_vld   (o_done_vld),
    .i_done_rdy   (i_done_rdy),
    .o_done_id    (o_done_id),
    .o_done_err   (o_done_err),
    .o_busy       (o_busy)
  );

  int         vec = 0;
  int         errs = 0;
  int         q_cfg_s[$];
  int         q_cfg_m[$];
  longint     q_beats[$];
  logic [4:0] q_done[$];
  int         n_vld_cyc = 0;
  int         n_go = 0;
  int         n_done = 0;
  bit         conv_en = 1'b1;

  int         es, em;
  logic [4:0] ed;

  // Config and completion scoreboard; handshakes seen at negedge complete on the next posedge.
  always @(negedge clk) begin
    if (!i_rst) begin
      if (o_conv_vld) n_vld_cyc++;
      if (o_src_go) n_go++;
      if (o_conv_vld && i_conv_rdy) begin
        vec++;
        if (q_cfg_s.size() == 0) begin
          errs++;
          $display("FAIL cfg_unexpected: s_ofs=%0d m_ofs=%0d, none expected", o_conv_s_ofs, o_conv_m_ofs);
        end else begin
          es = q_cfg_s.pop_front();
          em = q_cfg_m.pop_front();
          if ({30'd0, o_conv_s_ofs} !== es || {30'd0, o_conv_m_ofs} !== em) begin
            errs++;
            $display("FAIL cfg_ofs: got s=%0d m=%0d, want s=%0d m=%0d", o_conv_s_ofs, o_conv_m_ofs, es, em);
          end
        end
      end
      if (o_done_vld && i_done_rdy) begin
        n_done++;
        vec++;
        if (q_done.size() == 0) begin
          errs++;
          $display("FAIL done_unexpected: id=%0d err=%0b, none expected", o_done_id, o_done_err);
        end else begin
          ed = q_done.pop_front();
          if (o_done_id !== ed[3:0] || o_done_err !== ed[4]) begin
            errs++;
            $display("FAIL done: got id=%0d err=%0b, want id=%0d err=%0b", o_done_id, o_done_err, ed[3:0], ed[4]);
          end
        end
      end
    end
  end

  // Converter model: after src_go, emits the queued beat count on m_axis, tlast on the final beat.
  initial begin : conv_model
    longint left;
    bit     hs, go;
    left = 0;
    forever begin
      @(negedge clk);
      hs = i_mon_tvld & i_mon_trdy;
      go = o_src_go;
      @(posedge clk);
      #1;
      if (i_rst) begin
        left = 0;
      end else begin
        if (hs && left > 0) left--;
        if (go) begin
          if (q_beats.size() == 0) begin
            vec++;
            errs++;
            $display("FAIL src_go_unexpected: pulse with no queued transfer, want none");
          end else begin
            left = q_beats.pop_front();
          end
        end
      end
      i_mon_tvld  = (left > 0);
      i_mon_tlast = (left == 1);
      i_mon_trdy  = ($urandom_range(0, 3) != 0);
      i_conv_rdy  = conv_en && ($urandom_range(0, 1) == 1);
    end
  end

  task automatic send_cmd(input logic [31:0] sa, input logic [31:0] da, input logic [31:0] bl,
                          input logic [3:0] id, input longint beats, input bit track);
    bit     acc;
    longint nat;
    logic   err;
    acc = 1'b0;
    i_cmd_saddr = sa;
    i_cmd_daddr = da;
    i_cmd_blen  = bl;
    i_cmd_id    = id;
    i_cmd_vld   = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      acc = o_cmd_rdy;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) begin
      vec++;
      errs++;
      $display("FAIL cmd_accept_timeout: id=%0d not accepted, want accept", id);
      return;
    end
    nat = (longint'(da[1:0]) + longint'(bl) + 3) / 4;
    err = (bl == 32'd0);
    if (bl != 32'd0) begin
      q_cfg_s.push_back(int'(sa[1:0]));
      q_cfg_m.push_back(int'(da[1:0]));
      q_beats.push_back((beats < 0) ? nat : beats);
      if (beats >= 0 && beats != nat) err = 1'b1;
    end
    if (track) q_done.push_back({err, id});
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!o_busy && q_done.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vec++;
      errs++;
      $display("FAIL idle_timeout: busy=%0b pending=%0d, want idle", o_busy, q_done.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done_vld();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (o_done_vld) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vec++;
      errs++;
      $display("FAIL done_vld_timeout: done_vld=0, want 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vec++;
    if ({o_cmd_rdy, o_conv_vld, o_src_go, o_done_vld, o_done_err, o_busy, o_done_id, o_conv_s_ofs, o_conv_m_ofs} !== '0) begin
      errs++;
      $display("FAIL reset_outputs: rdy=%0b cvld=%0b go=%0b dvld=%0b busy=%0b, want all 0",
               o_cmd_rdy, o_conv_vld, o_src_go, o_done_vld, o_busy);
    end
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    vec++;
    if (o_cmd_rdy !== 1'b1 || o_busy !== 1'b0) begin
      errs++;
      $display("FAIL post_reset: rdy=%0b busy=%0b, want rdy=1 busy=0", o_cmd_rdy, o_busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    send_cmd(32'h0, 32'h3, 32'd10, 4'd1, -1, 1'b1);
    i_cmd_vld = 1'b0;
    wait_idle();
  endtask

  task automatic test_back_to_back();
    cmd_t tbl[4];
    tbl[0] = '{saddr: 32'h10, daddr: 32'h21, blen: 32'd7,  id: 4'd0};
    tbl[1] = '{saddr: 32'h02, daddr: 32'h03, blen: 32'd16, id: 4'd1};
    tbl[2] = '{saddr: 32'h41, daddr: 32'h00, blen: 32'd5,  id: 4'd2};
    tbl[3] = '{saddr: 32'h07, daddr: 32'hFF, blen: 32'd1,  id: 4'd3};
    i_done_rdy = 1'b0;
    send_cmd(32'h0, 32'h0, 32'd4, 4'd9, -1, 1'b1);
    i_cmd_vld = 1'b0;
    wait_done_vld();
    for (int k = 0; k < 4; k++) begin
      send_cmd(tbl[k].saddr, tbl[k].daddr, tbl[k].blen, tbl[k].id, -1, 1'b1);
    end
    i_cmd_vld = 1'b0;
    @(negedge clk);
    vec++;
    if (o_cmd_rdy !== 1'b0) begin
      errs++;
      $display("FAIL fifo_full_rdy: rdy=%0b, want 0", o_cmd_rdy);
    end
    @(posedge clk);
    #1;
    i_done_rdy = 1'b1;
    wait_idle();
  endtask

  task automatic test_zero_len();
    int v0, g0;
    v0 = n_vld_cyc;
    g0 = n_go;
    send_cmd(32'h0, 32'h0, 32'd0, 4'd5, -1, 1'b1);
    i_cmd_vld = 1'b0;
    wait_idle();
    vec++;
    if (n_vld_cyc - v0 !== 0 || n_go - g0 !== 0) begin
      errs++;
      $display("FAIL zero_len_untouched: conv_vld cycles=%0d go pulses=%0d, want 0 and 0",
               n_vld_cyc - v0, n_go - g0);
    end
  endtask

  task automatic test_beat_count();
    send_cmd(32'h3, 32'h2, 32'd2,   4'd6, -1, 1'b1);
    send_cmd(32'h0, 32'h0, 32'd200, 4'd7, 10, 1'b1);
    send_cmd(32'h1, 32'h0, 32'd40,  4'd8, 12, 1'b1);
    i_cmd_vld = 1'b0;
    wait_idle();
  endtask

  task automatic test_done_stall();
    i_done_rdy = 1'b0;
    send_cmd(32'h1, 32'h1, 32'd20, 4'd10, -1, 1'b1);
    send_cmd(32'h2, 32'h0, 32'd8,  4'd11, -1, 1'b1);
    i_cmd_vld = 1'b0;
    wait_done_vld();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      vec++;
      if (o_done_vld !== 1'b1 || o_done_id !== 4'd10 || o_conv_vld !== 1'b0) begin
        errs++;
        $display("FAIL done_stall: dvld=%0b id=%0d cvld=%0b, want dvld=1 id=10 cvld=0",
                 o_done_vld, o_done_id, o_conv_vld);
      end
    end
    @(posedge clk);
    #1;
    i_done_rdy = 1'b1;
    wait_idle();
  endtask

  task automatic test_reset_in_run();
    int g0, d0;
    bit seen;
    g0 = n_go;
    d0 = n_done;
    seen = 1'b0;
    send_cmd(32'h0, 32'h0, 32'd400, 4'd12, -1, 1'b0);
    i_cmd_vld = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (n_go != g0) begin
        seen = 1'b1;
        break;
      end
    end
    vec++;
    if (!seen) begin
      errs++;
      $display("FAIL run_start_timeout: go pulses=0, want 1");
    end
    repeat (5) @(posedge clk);
    #1;
    i_rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    vec++;
    if ({o_cmd_rdy, o_conv_vld, o_src_go, o_done_vld, o_done_err, o_busy} !== '0) begin
      errs++;
      $display("FAIL reset_in_run: rdy=%0b cvld=%0b go=%0b dvld=%0b err=%0b busy=%0b, want all 0",
               o_cmd_rdy, o_conv_vld, o_src_go, o_done_vld, o_done_err, o_busy);
    end
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    vec++;
    if (o_cmd_rdy !== 1'b1 || o_done_vld !== 1'b0) begin
      errs++;
      $display("FAIL after_reset_in_run: rdy=%0b dvld=%0b, want rdy=1 dvld=0", o_cmd_rdy, o_done_vld);
    end
    @(posedge clk);
    #1;
    vec++;
    if (n_done - d0 !== 0) begin
      errs++;
      $display("FAIL aborted_completion: completions=%0d, want 0", n_done - d0);
    end
    send_cmd(32'h1, 32'h3, 32'd33, 4'd13, -1, 1'b1);
    i_cmd_vld = 1'b0;
    wait_idle();
  endtask

  initial begin
    i_rst       = 1'b1;
    i_cmd_vld   = 1'b0;
    i_cmd_saddr = '0;
    i_cmd_daddr = '0;
    i_cmd_blen  = '0;
    i_cmd_id    = '0;
    i_conv_rdy  = 1'b0;
    i_mon_tvld  = 1'b0;
    i_mon_trdy  = 1'b0;
    i_mon_tlast = 1'b0;
    i_done_rdy  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_zero_len();
    test_beat_count();
    test_done_stall();
    test_reset_in_run();
    vec++;
    if (q_done.size() !== 0 || q_cfg_s.size() !== 0 || q_beats.size() !== 0) begin
      errs++;
      $display("FAIL leftover: done=%0d cfg=%0d beats=%0d, want 0 0 0",
               q_done.size(), q_cfg_s.size(), q_beats.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
